bit32_regfile: RTL and testbench

Two-read, one-write 32-bit register file feeding the `a` and `b` operands of the 32-bit ALU and accepting its result `r` and overflow flag `V` on the write-back port. Read ports are registered with write-first bypass, so an ALU result written in cycle N is visible on the operand outputs registered at that same edge. An overflow-trap path suppresses the write of a signed-overflowing result and latches a sticky trap indication for the control unit.

---
 rtl/bit32_regfile_if.sv | 29 ++
 rtl/bit32_regfile.sv | 79 +++++++
 tb/tb_bit32_regfile.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/bit32_regfile_if.sv
// Operand-read, write-back and trap signals between the 2R/1W register file and its ALU/control neighbours.
interface bit32_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              rd_en;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_v;
    logic              wr_trap_en;
    logic              trap_clr;
    logic              trap;
    logic [ADDR_W-1:0] trap_addr;

    modport master (
        output rd_en, rs_addr, rt_addr, wr_en, wr_addr, wr_data, wr_v, wr_trap_en, trap_clr,
        input  a, b, trap, trap_addr
    );

    modport slave (
        input  rd_en, rs_addr, rt_addr, wr_en, wr_addr, wr_data, wr_v, wr_trap_en, trap_clr,
        output a, b, trap, trap_addr
    );
endinterface

// File: rtl/bit32_regfile.sv
// Two-read/one-write register file with write-first bypass and a sticky signed-overflow trap.
// Read and write latency 1 cycle; no backpressure, rd_en low simply holds a/b.
module bit32_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic           clk,
    input  logic           reset_n,
    bit32_regfile_if.slave rf
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              trap_q, trap_d;
    logic [ADDR_W-1:0] trap_addr_q, trap_addr_d;
    logic              tev;
    logic              we_eff;

    always_comb begin
        tev    = rf.wr_en & rf.wr_v & rf.wr_trap_en;
        we_eff = rf.wr_en & (rf.wr_addr != '0) & ~(rf.wr_v & rf.wr_trap_en);

        regs_d = regs_q;
        if (we_eff) begin
            regs_d[rf.wr_addr] = rf.wr_data;
        end
        // Entry 0 forced to zero here so both the store and the bypass see r0 = 0.
        regs_d[0] = '0;

        // Reading the post-write array gives write-first bypass; trapped writes never land in it.
        a_d = a_q;
        b_d = b_q;
        if (rf.rd_en) begin
            a_d = regs_d[rf.rs_addr];
            b_d = regs_d[rf.rt_addr];
        end

        trap_d      = trap_q;
        trap_addr_d = trap_addr_q;
        if (tev) begin
            // A coincident clear frees the slot, so the new trap is recorded.
            if (!trap_q || rf.trap_clr) begin
                trap_d      = 1'b1;
                trap_addr_d = rf.wr_addr;
            end
        end else if (rf.trap_clr) begin
            trap_d      = 1'b0;
            trap_addr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            a_q         <= '0;
            b_q         <= '0;
            trap_q      <= 1'b0;
            trap_addr_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            a_q         <= a_d;
            b_q         <= b_d;
            trap_q      <= trap_d;
            trap_addr_q <= trap_addr_d;
        end
    end

    assign rf.a         = a_q;
    assign rf.b         = b_q;
    assign rf.trap      = trap_q;
    assign rf.trap_addr = trap_addr_q;
endmodule

// File: tb/tb_bit32_regfile.sv
// Directed vector table plus randomized run against a behavioural register-file model.
module tb_bit32_regfile;
    logic clk = 1'b0;
    logic reset_n;

    bit32_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    bit32_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rf      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rd_en;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        v;
        logic        te;
        logic        clr;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        et;
        logic [4:0]  eta;
    } vec_t;

    vec_t vecs[17];

    logic [31:0] m_regs [32];
    logic [31:0] m_a, m_b;
    logic        m_trap;
    logic [4:0]  m_taddr;

    function automatic vec_t mk(logic rd, logic [4:0] rs, logic [4:0] rt, logic we, logic [4:0] wa,
                                logic [31:0] wd, logic v, logic te, logic clr,
                                logic [31:0] ea, logic [31:0] eb, logic et, logic [4:0] eta);
        vec_t r;
        r.rd_en = rd; r.rs = rs; r.rt = rt; r.we = we; r.wa = wa; r.wd = wd;
        r.v = v; r.te = te; r.clr = clr; r.ea = ea; r.eb = eb; r.et = et; r.eta = eta;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rd, input logic [4:0] rs, input logic [4:0] rt, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd, input logic v,
                         input logic te, input logic clr);
        bus.rd_en = rd; bus.rs_addr = rs; bus.rt_addr = rt; bus.wr_en = we; bus.wr_addr = wa;
        bus.wr_data = wd; bus.wr_v = v; bus.wr_trap_en = te; bus.trap_clr = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_a = '0; m_b = '0; m_trap = 1'b0; m_taddr = '0;
    endtask

    // Apply the currently driven inputs to the model: write (unless trapped or r0), then read.
    task automatic model_step();
        logic t;
        t = bus.wr_en && bus.wr_v && bus.wr_trap_en;
        if (bus.wr_en && !t && bus.wr_addr != 5'd0) m_regs[bus.wr_addr] = bus.wr_data;
        if (t) begin
            if (!m_trap || bus.trap_clr) begin
                m_trap = 1'b1;
                m_taddr = bus.wr_addr;
            end
        end else if (bus.trap_clr) begin
            m_trap = 1'b0;
            m_taddr = '0;
        end
        if (bus.rd_en) begin
            m_a = m_regs[bus.rs_addr];
            m_b = m_regs[bus.rt_addr];
        end
    endtask

    task automatic step_check(input string nm);
        model_step();
        tick();
        check({nm, ".a"}, bus.a, m_a);
        check({nm, ".b"}, bus.b, m_b);
        check({nm, ".trap"}, {31'd0, bus.trap}, {31'd0, m_trap});
        check({nm, ".trap_addr"}, {27'd0, bus.trap_addr}, {27'd0, m_taddr});
    endtask

    initial begin
        //              rd rs  rt  we wa  wd            v  te clr  exp_a         exp_b         trap addr
        vecs[0]  = mk(1, 0,  0,  1, 7,  32'hDEADBEEF, 0, 0, 0,  32'h0,        32'h0,        0,   0);
        vecs[1]  = mk(1, 7,  0,  0, 0,  32'h0,        0, 0, 0,  32'hDEADBEEF, 32'h0,        0,   0);
        vecs[2]  = mk(1, 0,  0,  1, 0,  32'h12345678, 0, 0, 0,  32'h0,        32'h0,        0,   0);
        vecs[3]  = mk(1, 0,  7,  0, 0,  32'h0,        0, 0, 0,  32'h0,        32'hDEADBEEF, 0,   0);
        vecs[4]  = mk(1, 3,  3,  1, 3,  32'h000000FF, 0, 0, 0,  32'h000000FF, 32'h000000FF, 0,   0);
        vecs[5]  = mk(1, 3,  4,  1, 4,  32'h11111111, 0, 0, 0,  32'h000000FF, 32'h11111111, 0,   0);
        vecs[6]  = mk(1, 4,  4,  1, 4,  32'h80000000, 1, 1, 0,  32'h11111111, 32'h11111111, 1,   4);
        vecs[7]  = mk(1, 9,  4,  1, 9,  32'h00001234, 1, 1, 0,  32'h0,        32'h11111111, 1,   4);
        vecs[8]  = mk(1, 9,  9,  1, 9,  32'hABCD0000, 1, 0, 0,  32'hABCD0000, 32'hABCD0000, 1,   4);
        vecs[9]  = mk(1, 4,  9,  0, 0,  32'h0,        0, 0, 1,  32'h11111111, 32'hABCD0000, 0,   0);
        vecs[10] = mk(1, 12, 0,  1, 12, 32'h00000005, 1, 1, 1,  32'h0,        32'h0,        1,  12);
        vecs[11] = mk(1, 12, 7,  1, 0,  32'h00000009, 1, 1, 1,  32'h0,        32'hDEADBEEF, 1,   0);
        vecs[12] = mk(0, 2,  2,  1, 2,  32'hCAFEF00D, 0, 0, 0,  32'h0,        32'hDEADBEEF, 1,   0);
        vecs[13] = mk(1, 2,  2,  0, 0,  32'h0,        0, 0, 0,  32'hCAFEF00D, 32'hCAFEF00D, 1,   0);
        vecs[14] = mk(1, 31, 5,  0, 0,  32'h0,        0, 0, 1,  32'h0,        32'h0,        0,   0);
        vecs[15] = mk(1, 5,  3,  0, 5,  32'h00000077, 1, 1, 0,  32'h0,        32'h000000FF, 0,   0);
        vecs[16] = mk(1, 7,  2,  1, 20, 32'h00000001, 1, 1, 0,  32'hDEADBEEF, 32'hCAFEF00D, 1,  20);

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        check("reset.a", bus.a, 32'h0);
        check("reset.b", bus.b, 32'h0);
        check("reset.trap", {31'd0, bus.trap}, 32'h0);
        check("reset.trap_addr", {27'd0, bus.trap_addr}, 32'h0);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rd_en, vecs[i].rs, vecs[i].rt, vecs[i].we, vecs[i].wa, vecs[i].wd,
                  vecs[i].v, vecs[i].te, vecs[i].clr);
            tick();
            check($sformatf("vec%0d.a", i), bus.a, vecs[i].ea);
            check($sformatf("vec%0d.b", i), bus.b, vecs[i].eb);
            check($sformatf("vec%0d.trap", i), {31'd0, bus.trap}, {31'd0, vecs[i].et});
            check($sformatf("vec%0d.trap_addr", i), {27'd0, bus.trap_addr}, {27'd0, vecs[i].eta});
        end

        // Preload r5/r31 so the async reset has something to clear.
        drive(1, 5, 31, 1, 5, 32'hA5A5A5A5, 0, 0, 0);
        tick();
        drive(1, 5, 31, 1, 31, 32'h5A5A5A5A, 0, 0, 0);
        tick();
        check("preload.a", bus.a, 32'hA5A5A5A5);
        check("preload.b", bus.b, 32'h5A5A5A5A);

        // Async reset between edges, held across an edge carrying a write to r6.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst.a", bus.a, 32'h0);
        check("async_rst.b", bus.b, 32'h0);
        check("async_rst.trap", {31'd0, bus.trap}, 32'h0);
        check("async_rst.trap_addr", {27'd0, bus.trap_addr}, 32'h0);
        drive(1, 6, 6, 1, 6, 32'h66666666, 0, 0, 0);
        tick();
        check("rst_edge_write.a", bus.a, 32'h0);
        #2;
        reset_n = 1'b1;
        model_reset();

        drive(1, 5, 31, 0, 0, 0, 0, 0, 0);
        step_check("post_rst_r5_r31");
        drive(1, 6, 7, 0, 0, 0, 0, 0, 0);
        step_check("post_rst_r6_r7");

        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 7));
            if (($urandom & 32'h7) == 0) wa = 5'($urandom);
            drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom), wa, $urandom, 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 9) == 0));
            step_check($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
